mux32: RTL and testbench

Single-bit 32-to-1 selector with a registered output. One of 32 discrete data inputs `I0`..`I31` is chosen by a 5-bit select `S`, and the result is presented on `Y` one clock after sampling. It serves as a leaf routing primitive wherever a datapath picks one of 32 single-bit sources, such as status-flag or test-point selection.

---
 rtl/mux32_pkg.sv | 9 +
 rtl/mux32_mux8to1.sv | 15 +
 rtl/mux32.sv | 75 +++++++
 tb/tb_mux32.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mux32_pkg.sv
// Shared constants and types for the 32-to-1 single-bit selector.
package mux32_pkg;

   localparam int MUX32_N_IN  = 32;
   localparam int MUX32_SEL_W = 5;

   typedef logic [MUX32_SEL_W-1:0] mux32_sel_t;

endpackage : mux32_pkg

// File: rtl/mux32_mux8to1.sv
// Combinational 8-to-1 single-bit selector used as the leaf stage of mux32.
import mux32_pkg::*;

module mux8to1 (
   input  logic [7:0] d,
   input  logic [2:0] sel,
   output logic       y
);

   // An X/Z select propagates X; unselected inputs never reach y.
   always_comb begin
      y = d[sel];
   end

endmodule : mux8to1

// File: rtl/mux32.sv
// 32-to-1 single-bit selector with a registered output (one cycle latency).
import mux32_pkg::*;

module mux32 (
   input  logic I0,
   input  logic I1,
   input  logic I2,
   input  logic I3,
   input  logic I4,
   input  logic I5,
   input  logic I6,
   input  logic I7,
   input  logic I8,
   input  logic I9,
   input  logic I10,
   input  logic I11,
   input  logic I12,
   input  logic I13,
   input  logic I14,
   input  logic I15,
   input  logic I16,
   input  logic I17,
   input  logic I18,
   input  logic I19,
   input  logic I20,
   input  logic I21,
   input  logic I22,
   input  logic I23,
   input  logic I24,
   input  logic I25,
   input  logic I26,
   input  logic I27,
   input  logic I28,
   input  logic I29,
   input  logic I30,
   input  logic I31,
   input  logic [MUX32_SEL_W-1:0] S,
   output logic Y,
   input  logic clk,
   input  logic rst
);

   logic [MUX32_N_IN-1:0] vec;
   mux32_sel_t            sel;
   logic [3:0]            grp_y;
   logic                  y_d;
   logic                  y_q;

   assign vec = {I31, I30, I29, I28, I27, I26, I25, I24,
                 I23, I22, I21, I20, I19, I18, I17, I16,
                 I15, I14, I13, I12, I11, I10, I9,  I8,
                 I7,  I6,  I5,  I4,  I3,  I2,  I1,  I0};
   assign sel = S;

   // Four 8:1 leaves on S[2:0], then a 4:1 stage on S[4:3].
   for (genvar g = 0; g < 4; g++) begin : g_grp
      mux8to1 u_grp (
         .d   (vec[g*8 +: 8]),
         .sel (sel[2:0]),
         .y   (grp_y[g])
      );
   end

   always_comb begin
      y_d = grp_y[sel[4:3]];
   end

   always_ff @(posedge clk) begin
      if (rst) y_q <= 1'b0;
      else     y_q <= y_d;
   end

   assign Y = y_q;

endmodule : mux32

// File: tb/tb_mux32.sv
// Directed self-checking bench for mux32.
module tb_mux32;

   logic [31:0] iv;
   logic [4:0]  s;
   logic        y;
   logic        clk;
   logic        rst;
   int          n_tests;
   int          n_fail;

   mux32 dut (
      .I0(iv[0]),   .I1(iv[1]),   .I2(iv[2]),   .I3(iv[3]),
      .I4(iv[4]),   .I5(iv[5]),   .I6(iv[6]),   .I7(iv[7]),
      .I8(iv[8]),   .I9(iv[9]),   .I10(iv[10]), .I11(iv[11]),
      .I12(iv[12]), .I13(iv[13]), .I14(iv[14]), .I15(iv[15]),
      .I16(iv[16]), .I17(iv[17]), .I18(iv[18]), .I19(iv[19]),
      .I20(iv[20]), .I21(iv[21]), .I22(iv[22]), .I23(iv[23]),
      .I24(iv[24]), .I25(iv[25]), .I26(iv[26]), .I27(iv[27]),
      .I28(iv[28]), .I29(iv[29]), .I30(iv[30]), .I31(iv[31]),
      .S(s),
      .Y(y),
      .clk(clk),
      .rst(rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle so outputs are sampled away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      iv  = 32'h0000_0001;
      s   = 5'd0;
      for (int c = 0; c < 2; c++) begin
         step();
         n_tests++;
         if (y !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold cycle %0d: Y=%b expected 0", c, y);
         end
      end
      rst = 1'b0;
      step();
      n_tests++;
      if (y !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: Y=%b expected 1", y);
      end
   endtask

   task automatic test_walking_one();
      for (int n = 0; n < 32; n++) begin
         iv = 32'd1 << n;
         s  = 5'(n);
         step();
         n_tests++;
         if (y !== 1'b1) begin
            n_fail++;
            $display("FAIL walk1 n=%0d: Y=%b expected 1", n, y);
         end
         s = 5'((n + 31) % 32);
         step();
         n_tests++;
         if (y !== 1'b0) begin
            n_fail++;
            $display("FAIL walk1_prev n=%0d S=%0d: Y=%b expected 0", n, s, y);
         end
      end
   endtask

   task automatic test_walking_zero();
      for (int n = 0; n < 32; n++) begin
         iv = ~(32'd1 << n);
         s  = 5'(n);
         step();
         n_tests++;
         if (y !== 1'b0) begin
            n_fail++;
            $display("FAIL walk0 n=%0d: Y=%b expected 0", n, y);
         end
         s = 5'((n + 1) % 32);
         step();
         n_tests++;
         if (y !== 1'b1) begin
            n_fail++;
            $display("FAIL walk0_next n=%0d S=%0d: Y=%b expected 1", n, s, y);
         end
      end
   endtask

   task automatic test_latency();
      logic exp_y;
      iv     = 32'h0000_0000;
      iv[5]  = 1'b1;
      iv[26] = 1'b0;
      s      = 5'd26;
      step();
      for (int c = 0; c < 8; c++) begin
         s     = (c % 2 == 0) ? 5'd5 : 5'd26;
         exp_y = (c % 2 == 0) ? 1'b1 : 1'b0;
         n_tests++;
         if (y !== 1'b0 && c % 2 == 0) begin
            n_fail++;
            $display("FAIL latency_pre cycle %0d: Y=%b expected 0", c, y);
         end else if (y !== 1'b1 && c % 2 == 1) begin
            n_fail++;
            $display("FAIL latency_pre cycle %0d: Y=%b expected 1", c, y);
         end
         step();
         n_tests++;
         if (y !== exp_y) begin
            n_fail++;
            $display("FAIL latency cycle %0d: Y=%b expected %b", c, y, exp_y);
         end
      end
   endtask

   task automatic test_isolation();
      iv     = 32'hxxxx_xxxx;
      iv[17] = 1'b1;
      s      = 5'd17;
      step();
      n_tests++;
      if (y !== 1'b1) begin
         n_fail++;
         $display("FAIL isolation: Y=%b expected 1", y);
      end
   endtask

   task automatic test_reset_midstream();
      iv  = 32'h8000_0000;
      s   = 5'd31;
      rst = 1'b0;
      step();
      n_tests++;
      if (y !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pre: Y=%b expected 1", y);
      end
      rst = 1'b1;
      step();
      n_tests++;
      if (y !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_rst: Y=%b expected 0", y);
      end
      rst = 1'b0;
      step();
      n_tests++;
      if (y !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_release: Y=%b expected 1", y);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      iv      = 32'h0;
      s       = 5'd0;
      #2;
      test_reset();
      test_walking_one();
      test_walking_zero();
      test_latency();
      test_isolation();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mux32
